// File: rtl/video_pkg.sv
`default_nettype none
// ============================================================================
// Module      : video_pkg
// Description : Shared constants and types for the BBC-to-VGA line-doubling
//               video path. This package has no ports. It is imported by
//               line_buffer and vga_scan_doubler.
// Revision    : 1.0 - initial release
// ============================================================================
package video_pkg;

  localparam int LINE_LEN_DEF    = 1024;  // samples per input line / pixels per output line
  localparam int HSYNC_WIDTH_DEF = 128;   // output hsync low time, clock32 cycles
  localparam int LB_AW           = 11;    // line buffer address: {bank, x[9:0]}
  localparam int LB_DEPTH        = 1 << LB_AW;

  typedef logic [2:0] rgb_t;  // {r, g, b}

  // Widen a 1-bit core colour to a 4-bit VGA DAC channel.
  function automatic logic [3:0] rep4(input logic b);
    return {4{b}};
  endfunction

endpackage
`default_nettype wire

// File: rtl/line_buffer.sv
`default_nettype none
// ============================================================================
// Module      : line_buffer
// Description : Simple dual-port 2048x3 RAM used as a ping-pong line store.
//               One write port and one registered read port, both on clock32.
//               The array has no reset, so it maps onto iCE40 EBR.
// Ports       : clock32  - system clock
//               wr_en    - write strobe
//               wr_addr  - write address {bank, x}
//               wr_data  - pixel to store
//               rd_addr  - read address {bank, x}
//               rd_data  - registered read data (one cycle after rd_addr)
// Revision    : 1.0 - initial release
// ============================================================================
module line_buffer
  import video_pkg::*;
(
  input  logic             clock32,
  input  logic             wr_en,
  input  logic [LB_AW-1:0] wr_addr,
  input  rgb_t             wr_data,
  input  logic [LB_AW-1:0] rd_addr,
  output rgb_t             rd_data
);

  rgb_t mem [0:LB_DEPTH-1];
  rgb_t rd_data_q;

  // The read and write ports always target opposite banks, so the
  // read-during-write ordering never matters.
  always_ff @(posedge clock32) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data_q <= mem[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/vga_scan_doubler.sv
`default_nettype none
// ============================================================================
// Module      : vga_scan_doubler
// Description : Converts the 15.625 kHz BBC RGB/sync stream into 31.25 kHz
//               VGA timing by line-doubling. Each input line is sampled at
//               16 MHz into one half of a ping-pong line buffer. It is then
//               replayed twice at 32 MHz from the other half. In bypass mode
//               the block passes the composite-sync 15 kHz video through.
// Ports       : clock32            - 32 MHz system clock (sole clock)
//               reset_n            - asynchronous active-low reset
//               double_en          - 1 = line-doubled VGA, 0 = 15 kHz bypass
//               in_r/in_g/in_b     - core pixel bits
//               in_hs/in_vs        - core syncs, active high
//               red/green/blue     - 4-bit VGA channels
//               hsync/vsync        - VGA syncs, active low
// Revision    : 1.0 - initial release
// ============================================================================
module vga_scan_doubler
  import video_pkg::*;
#(
  parameter int LINE_LEN    = LINE_LEN_DEF,
  parameter int HSYNC_WIDTH = HSYNC_WIDTH_DEF
) (
  input  logic       clock32,
  input  logic       reset_n,
  input  logic       double_en,
  input  logic       in_r,
  input  logic       in_g,
  input  logic       in_b,
  input  logic       in_hs,
  input  logic       in_vs,
  output logic [3:0] red,
  output logic [3:0] green,
  output logic [3:0] blue,
  output logic       hsync,
  output logic       vsync
);

  localparam int           X_W        = LB_AW - 1;
  localparam logic [X_W:0] IN_X_SAT   = (X_W + 1)'(LINE_LEN);
  localparam logic [X_W:0] HS_END     = (X_W + 1)'(HSYNC_WIDTH);
  localparam logic [X_W-1:0] OUT_X_LAST = X_W'(LINE_LEN - 1);

  // Input sampling registers. The core syncs and pixels are registered once
  // before use. A rising edge of in_hs therefore acts one edge after it is
  // first seen.
  rgb_t           in_rgb_q,  in_rgb_d;
  logic           in_hs_q,   in_hs_d;
  logic           in_vs_q,   in_vs_d;
  logic           in_hs_d_q, in_hs_d_d;    // previous sampled in_hs
  // Write side.
  logic           cap_ph_q,  cap_ph_d;
  logic [X_W:0]   in_x_q,    in_x_d;       // saturates at LINE_LEN
  logic           wr_bank_q, wr_bank_d;
  // Read side.
  logic [X_W-1:0] out_x_q,   out_x_d;
  logic           blank_q,   blank_d;      // sync interval, aligned with RAM data
  logic           vs_lat_q,  vs_lat_d;
  // Output registers.
  logic [3:0]     red_q,     red_d;
  logic [3:0]     green_q,   green_d;
  logic [3:0]     blue_q,    blue_d;
  logic           hsync_q,   hsync_d;
  logic           vsync_q,   vsync_d;

  logic           hs_rise;
  logic           wr_en;
  rgb_t           rd_rgb;

  always_comb begin
    hs_rise = in_hs_q & ~in_hs_d_q;
    // A sample that coincides with a line start is dropped. The new line
    // begins writing at x = 0 on the following sample.
    wr_en   = cap_ph_q & ~hs_rise & (in_x_q < IN_X_SAT);

    in_rgb_d  = {in_r, in_g, in_b};
    in_hs_d   = in_hs;
    in_vs_d   = in_vs;
    in_hs_d_d = in_hs_q;

    cap_ph_d  = hs_rise ? 1'b0 : ~cap_ph_q;
    wr_bank_d = wr_bank_q ^ hs_rise;

    in_x_d = in_x_q;
    if (hs_rise) begin
      in_x_d = '0;
    end else if (wr_en) begin
      in_x_d = in_x_q + 1'b1;
    end

    // The read counter free-runs, so two output lines occur per input line.
    // A line start overrides the wrap and resynchronises the counter.
    if (hs_rise || (out_x_q == OUT_X_LAST)) begin
      out_x_d = '0;
    end else begin
      out_x_d = out_x_q + 1'b1;
    end

    // blank_q and vs_lat_q are registered one cycle after out_x. This puts
    // them in the same stage as the RAM read data.
    blank_d  = ({1'b0, out_x_q} < HS_END);
    vs_lat_d = (out_x_q == '0) ? in_vs_q : vs_lat_q;

    if (double_en) begin
      red_d   = blank_q ? 4'h0 : rep4(rd_rgb[2]);
      green_d = blank_q ? 4'h0 : rep4(rd_rgb[1]);
      blue_d  = blank_q ? 4'h0 : rep4(rd_rgb[0]);
      hsync_d = ~blank_q;
      vsync_d = ~vs_lat_q;
    end else begin
      red_d   = rep4(in_r);
      green_d = rep4(in_g);
      blue_d  = rep4(in_b);
      hsync_d = ~(in_hs | in_vs);
      vsync_d = 1'b1;
    end
  end

  always_ff @(posedge clock32 or negedge reset_n) begin
    if (!reset_n) begin
      in_rgb_q  <= '0;
      in_hs_q   <= 1'b0;
      in_vs_q   <= 1'b0;
      in_hs_d_q <= 1'b0;
      cap_ph_q  <= 1'b0;
      in_x_q    <= IN_X_SAT;
      wr_bank_q <= 1'b0;
      out_x_q   <= '0;
      blank_q   <= 1'b1;
      vs_lat_q  <= 1'b0;
      red_q     <= 4'h0;
      green_q   <= 4'h0;
      blue_q    <= 4'h0;
      hsync_q   <= 1'b1;
      vsync_q   <= 1'b1;
    end else begin
      in_rgb_q  <= in_rgb_d;
      in_hs_q   <= in_hs_d;
      in_vs_q   <= in_vs_d;
      in_hs_d_q <= in_hs_d_d;
      cap_ph_q  <= cap_ph_d;
      in_x_q    <= in_x_d;
      wr_bank_q <= wr_bank_d;
      out_x_q   <= out_x_d;
      blank_q   <= blank_d;
      vs_lat_q  <= vs_lat_d;
      red_q     <= red_d;
      green_q   <= green_d;
      blue_q    <= blue_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
    end
  end

  line_buffer u_line_buffer (
    .clock32 (clock32),
    .wr_en   (wr_en),
    .wr_addr ({wr_bank_q, in_x_q[X_W-1:0]}),
    .wr_data (in_rgb_q),
    .rd_addr ({~wr_bank_q, out_x_q}),
    .rd_data (rd_rgb)
  );

  assign red   = red_q;
  assign green = green_q;
  assign blue  = blue_q;
  assign hsync = hsync_q;
  assign vsync = vsync_q;

endmodule
`default_nettype wire
